// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store funct3 encodings, LSU FSM states and
// the funct3 legality rule used by the data-memory path.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Unsigned loads have no store counterpart, so bu/hu stores are rejected.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (we && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane steering for the LSU: byte enables and replicated store
// word on the write side, lane select plus sign/zero extension on the read side.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rword >> {addr_lo, 3'b000});
  assign half_sel = 16'(rword >> {addr_lo[1], 4'b0000});

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be       = 4'b0000;
    wword    = wdata;
    rdata    = rword;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rdata    = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
        misalign = addr_lo[0];
      end
      F3_W: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit with word-organised data memory and a fixed number of
// wait states between request acceptance and the one-cycle response pulse.
module dmem_lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  lsu_state_e  state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [2**ADDR_W];

  logic        accept, commit;
  logic        acc_we, acc_err, oor, misalign;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr, acc_wdata;
  logic [ADDR_W-1:0] widx;
  logic [31:0] rword, wword, ld_data;
  logic [3:0]  be;

  assign accept = (state == ST_IDLE) && req_valid;
  assign commit = (WAIT_CYCLES == 0) ? accept : ((state == ST_WAIT) && (cnt == 4'd0));

  // With no wait states the commit edge is the accept edge, so the live request is used.
  always_comb begin
    acc_we    = lat_we;
    acc_f3    = lat_f3;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign widx    = acc_addr[ADDR_W+1:2];
  assign rword   = mem[widx];
  assign oor     = |acc_addr[31:ADDR_W+2];
  assign acc_err = misalign || oor || f3_illegal(acc_f3, acc_we);

  lsu_align u_align (
    .funct3   (acc_f3),
    .addr_lo  (acc_addr[1:0]),
    .wdata    (acc_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_f3    <= req_funct3;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Memory is never reset; a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (commit) begin
        rsp_rdata <= (acc_err || acc_we) ? 32'd0 : ld_data;
        rsp_err   <= acc_err;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (1, 0 and 3 wait states) checked against
// a byte-array reference model with directed and random load/store traffic.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  logic [7:0]  mdl [3][4096];
  int          n_assert = 0;
  int          n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_lsu #(
      .ADDR_W      (10),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a byte array, access rules applied directly.
  task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rd);
    int size;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
           (we && (f3 == 3'd4 || f3 == 3'd5)) ||
           ((addr % size) != 0) || (addr >= 32'd4096);
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mdl[d][int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | ({24'd0, mdl[d][int'(addr) + i]} << (8*i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  task automatic rand_op(output logic we, output logic [2:0] f3,
                         output logic [31:0] addr, output logic [31:0] wdata);
    int sel;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
    else if (we) f3 = 3'($urandom_range(0, 2));
    else begin
      sel = $urandom_range(0, 4);
      f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
    end
    if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 63));
    else addr = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
    wdata = $urandom;
  endtask

  task automatic drive(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
  endtask

  // One isolated access, started at a falling edge, returning at a falling edge.
  task automatic access(input int d, input int w, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                        output logic [31:0] rd, output logic err);
    logic        e_err;
    logic [31:0] e_rd;
    int          k;
    chk({tag, " ready"}, 32'(req_ready[d]), 32'd1);
    drive(d, we, f3, addr, wdata);
    req_valid[d] = 1'b1;
    model_access(d, we, f3, addr, wdata, e_err, e_rd);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    drive(d, ~we, ~f3, $urandom, $urandom);
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(w));
    chk({tag, " rdata"}, rsp_rdata[d], e_rd);
    chk({tag, " err"}, 32'(rsp_err[d]), 32'(e_err));
    rd  = rsp_rdata[d];
    err = rsp_err[d];
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, " ready back"}, 32'(req_ready[d]), 32'd1);
    @(negedge clk);
  endtask

  // req_valid held high: responses must be spaced w+2 apart, ready low w+1 cycles.
  task automatic b2b(input int d, input int w, input int nreq);
    int          acc, got, last, low, cyc;
    logic        we, e_err, just_acc;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rd;
    logic [31:0] q_rd [$];
    logic        q_err [$];
    acc = 0; got = 0; last = -1; low = 0; cyc = 0;
    rand_op(we, f3, a, wd);
    drive(d, we, f3, a, wd);
    req_valid[d] = 1'b1;
    while (got < nreq && cyc < nreq * (w + 2) + 20) begin
      just_acc = 1'b0;
      if (req_ready[d]) begin
        if (acc < nreq) begin
          model_access(d, we, f3, a, wd, e_err, e_rd);
          q_rd.push_back(e_rd);
          q_err.push_back(e_err);
          acc++;
          just_acc = 1'b1;
        end else req_valid[d] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (just_acc) begin
        rand_op(we, f3, a, wd);
        drive(d, we, f3, a, wd);
      end
      if (rsp_valid[d]) begin
        chk("b2b pending", 32'(q_rd.size() > 0), 32'd1);
        if (q_rd.size() > 0) begin
          chk("b2b rdata", rsp_rdata[d], q_rd.pop_front());
          chk("b2b err", 32'(rsp_err[d]), 32'(q_err.pop_front()));
        end
        if (last >= 0) chk("b2b spacing", 32'(cyc - last), 32'(w + 2));
        last = cyc;
        got++;
      end
      if (!req_ready[d]) low++;
      else if (low > 0) begin
        chk("b2b ready low", 32'(low), 32'(w + 1));
        low = 0;
      end
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    chk("b2b count", 32'(got), 32'(nreq));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      drive(d, 1'b0, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < 4096; i++) mdl[d][i] = 8'd0;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset ready", 32'(req_ready[d]), 32'd1);
      chk("reset valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset rdata", rsp_rdata[d], 32'd0);
      chk("reset err", 32'(rsp_err[d]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for the low 256 bytes of every instance.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 64; i++)
        access(d, (d == 0) ? 1 : ((d == 1) ? 0 : 3), 1'b1, 3'b010, 32'(4 * i), 32'd0, "init", rd, er);

    access(0, 1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw10", rd, er);
    access(0, 1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10", rd, er);
    chk("lw10 value", rd, 32'hDEAD_BEEF);
    access(0, 1, 1'b1, 3'b000, 32'h11, 32'h0000_00AA, "sb11", rd, er);
    access(0, 1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10b", rd, er);
    chk("lw10b value", rd, 32'hDEAD_AAEF);
    access(0, 1, 1'b0, 3'b000, 32'h11, 32'd0, "lb11", rd, er);
    chk("lb11 value", rd, 32'hFFFF_FFAA);
    access(0, 1, 1'b0, 3'b100, 32'h11, 32'd0, "lbu11", rd, er);
    chk("lbu11 value", rd, 32'h0000_00AA);
    access(0, 1, 1'b1, 3'b001, 32'h12, 32'h0000_8001, "sh12", rd, er);
    access(0, 1, 1'b0, 3'b001, 32'h12, 32'd0, "lh12", rd, er);
    chk("lh12 value", rd, 32'hFFFF_8001);
    access(0, 1, 1'b0, 3'b101, 32'h12, 32'd0, "lhu12", rd, er);
    chk("lhu12 value", rd, 32'h0000_8001);
    access(0, 1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10c", rd, er);
    chk("lw10c value", rd, 32'h8001_AAEF);

    // Reset during the wait state aborts the pending store.
    drive(0, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("abort busy", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort ready", 32'(req_ready[0]), 32'd1);
    chk("abort rdata", rsp_rdata[0], 32'd0);
    chk("abort err", 32'(rsp_err[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort valid", 32'(rsp_valid[0]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1, 1'b0, 3'b010, 32'h20, 32'd0, "lw20", rd, er);
    chk("lw20 value", rd, 32'd0);

    access(0, 1, 1'b0, 3'b010, 32'h13, 32'd0, "lw13", rd, er);
    chk("lw13 err", 32'(er), 32'd1);
    chk("lw13 rdata", rd, 32'd0);
    access(0, 1, 1'b1, 3'b001, 32'h11, 32'h0000_5555, "sh11", rd, er);
    chk("sh11 err", 32'(er), 32'd1);
    access(0, 1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10d", rd, er);
    chk("lw10d value", rd, 32'h8001_AAEF);
    access(0, 1, 1'b0, 3'b010, 32'h1000, 32'd0, "lw1000", rd, er);
    chk("lw1000 err", 32'(er), 32'd1);
    access(0, 1, 1'b0, 3'b011, 32'h10, 32'd0, "f3_011", rd, er);
    chk("f3_011 err", 32'(er), 32'd1);
    access(0, 1, 1'b1, 3'b100, 32'h10, 32'h0000_0077, "sbu", rd, er);
    chk("sbu err", 32'(er), 32'd1);
    access(0, 1, 1'b0, 3'b010, 32'h10, 32'd0, "lw10e", rd, er);
    chk("lw10e value", rd, 32'h8001_AAEF);

    for (int i = 0; i < 60; i++) begin
      rand_op(we, f3, a, wd);
      access(0, 1, we, f3, a, wd, "rand", rd, er);
    end

    b2b(1, 0, 30);
    b2b(2, 3, 30);
    b2b(0, 1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
